uart_rx_fifo: RTL
=================

# uart_rx_fifo

Serial receiver for the SOC's UART: the receive-side counterpart of the `corescore_emitter_uart` transmitter. It samples the `RXD` pin, deserialises 8N1 frames at a fixed baud rate, and buffers received bytes in a small FIFO. The FIFO exposes a valid/ready pop port that the SOC maps onto the IO page, so firmware can poll and read bytes with `LW`.

## Interface

Parameters:
- `clk_freq_hz`, default 12000000: `clk` frequency.
- `baud_rate`, default 115200: line rate.
- `FIFO_DEPTH`, default 4: receive buffer entries. Must be a power of two, at least 2.

Ports:
- `clk` input 1: system clock.
- `resetn` input 1: reset, asynchronous and active-low.
- `i_rx` input 1: serial line, asynchronous to `clk`, idle high.
- `o_data` output 8: byte at the FIFO head. Valid only while `o_valid` is high.
- `o_valid` output 1: FIFO not empty.
- `i_ready` input 1: pop request. It is ignored when `o_valid` is low.
- `o_frame_err` output 1: sticky flag, stop bit sampled low.
- `o_overrun` output 1: sticky flag, a byte was dropped because the FIFO was full.
- `i_err_clr` input 1: one-cycle pulse that clears both sticky flags.

## Operation

- Bit period `DIV = clk_freq_hz / baud_rate`, integer truncation. Elaboration fails if `DIV < 4`.
- `i_rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised value `rx_s`.
- One baud counter of width `$clog2(DIV)` counts down. A sample event occurs when the counter is 0; the counter then reloads `DIV-1`.
- State machine:
  - IDLE: on `rx_s==0`, load `DIV/2-1` and go to START.
  - START: at the sample event, if `rx_s==0` go to DATA with bit index 0. Otherwise treat it as a glitch and return to IDLE.
  - DATA: at each sample event, shift `rx_s` into bit 7 of the shift register (shift right, LSB first). After the 8th sample, go to STOP.
  - STOP: at the sample event:
    - if `rx_s==1`: push the byte, go to IDLE.
    - if `rx_s==0`: set `o_frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. A held-low line therefore never retriggers reception.
- FIFO:
  - Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally.
  - Empty when the pointers are equal. Full when the MSBs differ and the rest match.
  - `o_data` is the head entry, driven combinationally (first-word fall-through).
  - A pop happens when `o_valid && i_ready`.
  - A push while full with no pop that cycle drops the byte and sets `o_overrun`.
  - Push and pop in the same cycle both take effect, even when full; occupancy is unchanged.
- Sticky flags: a set and `i_err_clr` in the same cycle leaves the flag at 1 (set wins).

## Timing

- Reset values: `o_valid=0`, `o_frame_err=0`, `o_overrun=0`, `o_data` don't-care. State is IDLE, pointers 0, counter 0, synchroniser flops 1.
- Sampling instants:
  - Start-bit check at `DIV/2` cycles after the first cycle `rx_s` is seen low.
  - Data bit k sampled at `DIV/2 + (k+1)*DIV`.
  - Stop bit sampled at `DIV/2 + 9*DIV`.
- Push happens on the stop-sample cycle. `o_valid` rises on the following cycle.
- Total latency from the `i_rx` falling edge to `o_valid`: `2 + DIV/2 + 9*DIV + 1` cycles, with ±1 cycle of synchroniser uncertainty.
- A pop updates `o_data`/`o_valid` on the next clock edge.
- Back-to-back frames: returning to IDLE at mid-stop leaves `DIV/2` cycles of margin before the next start edge.
- `resetn` asserted mid-frame forces every register to its reset value immediately. The partial byte is lost, and FIFO contents are cleared.

## Structure

- `uart_defs.vh` holds the shared constants:
  - state encodings `UART_RX_IDLE..UART_RX_BREAK`
  - the frame length 8
  - SOC IO bit assignments: `IO_UART_DAT_bit=1` and `IO_UART_CNTL_bit=2`, with RX status at CNTL bit 8 and overrun at bit 10; bit 9 is TX busy.
- Sub-module `uart_rx_sync_fifo` contains the pointer FIFO with a parameterised depth. The deserialiser FSM stays in the top module.

## Test plan

Bench parameters: `clk_freq_hz=1000000`, `baud_rate=100000` (`DIV=10`), `FIFO_DEPTH=4`.

- Single frame 0xA5, `i_ready=0` -> `o_valid` rises exactly at the cycle given in Timing; `o_data=0xA5`; flags 0.
- 0.3-bit low glitch on an idle line -> no push; FSM back in IDLE; `o_valid` stays 0.
- Frame 0x3C with the stop bit driven low, then line held low for 30 bit periods -> `o_frame_err=1`; no push; no new frame detected until the line goes high. A following 0x3C is then received correctly.
- Five frames 0x01..0x05 with no pops -> FIFO holds 0x01..0x04; `o_overrun=1`; four pops return 0x01..0x04 in order, then `o_valid=0`.
- FIFO full, `i_ready=1` on the cycle a 6th frame pushes -> no overrun; occupancy stays 4; new byte at tail; `i_err_clr` pulsed the same cycle a flag is set -> flag remains 1.
- `resetn` pulsed low during data bit 4 -> outputs at reset values within the same cycle; the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM states, frame length and
// the SOC IO-page bit assignments used by firmware to reach the receiver.
package uart_rx_fifo_pkg;

   localparam int unsigned FRAME_BITS = 8;

   // SOC IO page: data register, control register and its status bits.
   localparam int unsigned IO_UART_DAT_BIT   = 1;
   localparam int unsigned IO_UART_CNTL_BIT  = 2;
   localparam int unsigned CNTL_RX_VALID_BIT = 8;
   localparam int unsigned CNTL_TX_BUSY_BIT  = 9;
   localparam int unsigned CNTL_OVERRUN_BIT  = 10;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; a push that finds the
// FIFO full with no pop in the same cycle is dropped and reported.
module uart_rx_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_drop
);

   localparam int unsigned AW = $clog2(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_rx_sync_fifo: DEPTH must be a power of two, at least 2");
   end

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             empty, full, pop, wr_en;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop      = i_ready && !empty;
      // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
      wr_en    = i_push && (!full || pop);
      o_drop   = i_push && full && !pop;
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
      o_valid  = !empty;
      o_data   = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage has no reset; equal pointers already mark every entry as invalid.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronises RXD, samples mid-bit with a down-counting
// baud counter and buffers bytes in a small FIFO with sticky error flags.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int unsigned clk_freq_hz = 12000000,
   parameter int unsigned baud_rate   = 115200,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   input  logic       i_err_clr
);

   localparam int unsigned   DIV      = clk_freq_hz / baud_rate;
   localparam int unsigned   CW       = $clog2(DIV);
   localparam logic [CW-1:0] RELOAD   = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF     = CW'(DIV / 2 - 1);
   localparam logic [2:0]    LAST_BIT = 3'(FRAME_BITS - 1);

   if (DIV < 4) begin : g_div_check
      $error("uart_rx_fifo: clk_freq_hz / baud_rate must be at least 4");
   end

   rx_state_e     state_q, state_d;
   logic          sync_q, sync_d, rx_s_q, rx_s_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
   logic          sample, push, ferr_set, fifo_drop;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      sync_d    = i_rx;
      rx_s_d    = sync_q;
      sample    = (cnt_q == '0);
      cnt_d     = sample ? RELOAD : cnt_q - 1'b1;
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      ferr_set  = 1'b0;
      unique case (state_q)
         RX_IDLE: if (!rx_s_q) begin
            cnt_d   = HALF;
            state_d = RX_START;
         end
         RX_START: if (sample) begin
            state_d   = rx_s_q ? RX_IDLE : RX_DATA;
            bit_idx_d = '0;
         end
         RX_DATA: if (sample) begin
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_BIT) state_d = RX_STOP;
         end
         RX_STOP: if (sample) begin
            push     = rx_s_q;
            ferr_set = !rx_s_q;
            state_d  = rx_s_q ? RX_IDLE : RX_BREAK;
         end
         // A held-low line stays here so it cannot retrigger a start bit.
         RX_BREAK: if (rx_s_q) state_d = RX_IDLE;
         default:  state_d = RX_IDLE;
      endcase
      frame_err_d = ferr_set  | (frame_err_q & ~i_err_clr);
      overrun_d   = fifo_drop | (overrun_q   & ~i_err_clr);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= RX_IDLE;
         sync_q      <= 1'b1;
         rx_s_q      <= 1'b1;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         rx_s_q      <= rx_s_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   uart_rx_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (push),
      .i_data  (shift_q),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_drop  (fifo_drop)
   );

   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;

endmodule
